// File: rtl/rr_arb2_mux_pkg.sv
// Shared definitions for the round-robin front end of the 2:1 select mux.
// The select encodings must match the downstream mux's s input.
package rr_arb2_mux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // The loser of an arbitration round is favoured in the next one.
    function automatic logic prio_after(input logic winner_sel);
        return ~winner_sel;
    endfunction

endpackage

// File: rtl/rr_arb2_grant.sv
// Two-way round-robin grant: one-hot or zero, gated by en (buffer can load).
module rr_arb2_grant
    import rr_arb2_mux_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic prio,
    input  logic en,
    output logic grant_a,
    output logic grant_b
);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (en) begin
            // A wins when alone, or when contested and it holds priority.
            if (a_valid && (!b_valid || prio == SEL_A)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb2_mux.sv
// Round-robin arbiter for two valid/ready producers feeding a 1-entry output
// buffer that carries the payload and the mux select; per-source grant counters.
module rr_arb2_mux
    import rr_arb2_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_e       state_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_sel_reg;
    logic             prio_reg;

    logic             can_load;
    logic             grant_a;
    logic             grant_b;
    logic             accept;
    logic             win_sel;
    logic [WIDTH-1:0] win_data;
    logic [1:0]       beat_acc;
    logic [CNT_W-1:0] cnt_reg [2];

    // Draining and refilling in the same cycle keeps one beat per clock.
    assign can_load = (state_reg == BUF_EMPTY) || out_ready;

    rr_arb2_grant u_grant (
        .a_valid (a_valid),
        .b_valid (b_valid),
        .prio    (prio_reg),
        .en      (can_load),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign accept   = grant_a | grant_b;
    assign win_sel  = grant_b ? SEL_B : SEL_A;
    assign win_data = grant_b ? b_data : a_data;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_reg    <= BUF_EMPTY;
            out_data_reg <= '0;
            out_sel_reg  <= SEL_A;
            prio_reg     <= SEL_A;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_reg    <= BUF_FULL;
                        out_data_reg <= win_data;
                        out_sel_reg  <= win_sel;
                        prio_reg     <= prio_after(win_sel);
                    end
                end
                BUF_FULL: begin
                    if (accept) begin
                        out_data_reg <= win_data;
                        out_sel_reg  <= win_sel;
                        prio_reg     <= prio_after(win_sel);
                    end else if (out_ready) begin
                        // Payload and select hold their last values when drained.
                        state_reg <= BUF_EMPTY;
                    end
                end
                default: state_reg <= BUF_EMPTY;
            endcase
        end
    end

    assign beat_acc = {grant_b, grant_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge CLK or negedge RST_X) begin
                if (!RST_X) begin
                    cnt_reg[gi] <= '0;
                end else if (beat_acc[gi] && cnt_reg[gi] != CNT_MAX) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign out_valid = (state_reg == BUF_FULL);
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign cnt_a     = cnt_reg[0];
    assign cnt_b     = cnt_reg[1];

endmodule

// File: tb/tb_rr_arb2_mux.sv
// Scenario bench for rr_arb2_mux: expected beats are queued when offered and
// compared when the output buffer presents them.
module tb_rr_arb2_mux;

    typedef struct packed {
        logic [7:0] data;
        logic       sel;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_x = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, out_valid, out_sel;
    logic [7:0] out_data, cnt_a, cnt_b;

    logic       a2_valid = 1'b0, b2_valid = 1'b0, out2_ready = 1'b0;
    logic [7:0] a2_data = '0, b2_data = '0;
    logic       a2_ready, b2_ready, out2_valid, out2_sel;
    logic [7:0] out2_data;
    logic [1:0] cnt2_a, cnt2_b;

    beat_t sb_q[$];
    beat_t front;
    int    checks = 0;
    int    failures = 0;
    int    exp_cnt_a = 0;
    int    exp_cnt_b = 0;

    always #5 clk = ~clk;

    rr_arb2_mux #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK(clk), .RST_X(rst_x),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    rr_arb2_mux #(.WIDTH(8), .CNT_W(2)) dut2 (
        .CLK(clk), .RST_X(rst_x),
        .a_valid(a2_valid), .a_data(a2_data), .a_ready(a2_ready),
        .b_valid(b2_valid), .b_data(b2_data), .b_ready(b2_ready),
        .out_valid(out2_valid), .out_data(out2_data), .out_sel(out2_sel),
        .out_ready(out2_ready), .cnt_a(cnt2_a), .cnt_b(cnt2_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_x = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        #1;
        @(negedge clk);
        rst_x = 1'b1;
        sb_q.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 1'b0 ||
            cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h sel=%b cnt_a=%0d cnt_b=%0d, want all 0",
                     out_valid, out_data, out_sel, cnt_a, cnt_b);
        end
        @(negedge clk);
        rst_x = 1'b1;
        // Load a beat and hold it, then reset asynchronously mid-cycle.
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h77; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL reset_preload: valid=%b data=%h cnt_a=%0d, want 1 77 1",
                     out_valid, out_data, cnt_a);
        end
        #2;
        rst_x = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 1'b0 ||
            cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_async: valid=%b data=%h sel=%b cnt_a=%0d cnt_b=%0d, want all 0",
                     out_valid, out_data, out_sel, cnt_a, cnt_b);
        end
        $display("reset: async clear checked at t=%0t", $time);
        @(negedge clk);
        a_valid = 1'b0;
        rst_x = 1'b1;
        sb_q.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    task automatic test_single_a();
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
        end
        sb_q.push_back('{data: 8'h3C, sel: 1'b0});
        exp_cnt_a++;
        @(negedge clk);
        checks++;
        front = (sb_q.size() > 0) ? sb_q[0] : '0;
        if (out_valid !== 1'b1 || sb_q.size() == 0 || out_data !== front.data ||
            out_sel !== front.sel || cnt_a !== 8'(exp_cnt_a)) begin
            failures++;
            $display("FAIL single_out: valid=%b data=%h sel=%b cnt_a=%0d, want 1 %h %b %0d",
                     out_valid, out_data, out_sel, cnt_a, front.data, front.sel, exp_cnt_a);
        end
        $display("single: beat data=%h sel=%b", out_data, out_sel);
        a_valid = 1'b0;
        if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic test_alternation();
        logic exp_b;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                front = (sb_q.size() > 0) ? sb_q[0] : '0;
                if (out_valid !== 1'b1 || sb_q.size() == 0 ||
                    out_data !== front.data || out_sel !== front.sel) begin
                    failures++;
                    $display("FAIL alt_beat%0d: valid=%b data=%h sel=%b, want 1 %h %b",
                             i - 1, out_valid, out_data, out_sel, front.data, front.sel);
                end
                $display("alt: beat %0d data=%h sel=%b", i - 1, out_data, out_sel);
            end
            a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
            a_data = 8'h10 + 8'(i); b_data = 8'h80 + 8'(i);
            #1;
            exp_b = (i % 2 == 1);
            checks++;
            if (a_ready !== ~exp_b || b_ready !== exp_b) begin
                failures++;
                $display("FAIL alt_ready%0d: a_ready=%b b_ready=%b, want %b %b",
                         i, a_ready, b_ready, ~exp_b, exp_b);
            end
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            sb_q.push_back('{data: (exp_b ? b_data : a_data), sel: exp_b});
            if (exp_b) exp_cnt_b++; else exp_cnt_a++;
        end
        @(negedge clk);
        checks++;
        front = (sb_q.size() > 0) ? sb_q[0] : '0;
        if (out_valid !== 1'b1 || out_data !== front.data || out_sel !== front.sel) begin
            failures++;
            $display("FAIL alt_beat5: valid=%b data=%h sel=%b, want 1 %h %b",
                     out_valid, out_data, out_sel, front.data, front.sel);
        end
        $display("alt: beat 5 data=%h sel=%b", out_data, out_sel);
        a_valid = 1'b0; b_valid = 1'b0;
        if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
        checks++;
        if (cnt_a !== 8'd3 || cnt_b !== 8'd3) begin
            failures++;
            $display("FAIL alt_counts: cnt_a=%0d cnt_b=%0d, want 3 3", cnt_a, cnt_b);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h41; b_data = 8'hB2; out_ready = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_load: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
        end
        sb_q.push_back('{data: 8'h41, sel: 1'b0});
        exp_cnt_a++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            front = (sb_q.size() > 0) ? sb_q[0] : '0;
            if (out_valid !== 1'b1 || out_data !== front.data || out_sel !== front.sel ||
                a_ready !== 1'b0 || b_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: valid=%b data=%h sel=%b rdy=%b%b, want 1 %h %b 00",
                         i, out_valid, out_data, out_sel, a_ready, b_ready, front.data, front.sel);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: a_ready=%b b_ready=%b, want 0 1", a_ready, b_ready);
        end
        $display("stall: held beat data=%h sel=%b released", out_data, out_sel);
        if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
        sb_q.push_back('{data: 8'hB2, sel: 1'b1});
        exp_cnt_b++;
        @(negedge clk);
        checks++;
        front = (sb_q.size() > 0) ? sb_q[0] : '0;
        if (out_valid !== 1'b1 || out_data !== front.data || out_sel !== front.sel) begin
            failures++;
            $display("FAIL stall_winner: valid=%b data=%h sel=%b, want 1 %h %b",
                     out_valid, out_data, out_sel, front.data, front.sel);
        end
        $display("stall: winner data=%h sel=%b", out_data, out_sel);
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hA5; out_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: a_ready=%b b_ready=%b valid=%b, want 0 1 1",
                     a_ready, b_ready, out_valid);
        end
        if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
        sb_q.push_back('{data: 8'hA5, sel: 1'b1});
        exp_cnt_b++;
        @(negedge clk);
        checks++;
        front = (sb_q.size() > 0) ? sb_q[0] : '0;
        if (out_valid !== 1'b1 || out_data !== front.data || out_sel !== front.sel ||
            cnt_a !== 8'(exp_cnt_a) || cnt_b !== 8'(exp_cnt_b)) begin
            failures++;
            $display("FAIL b2b_out: valid=%b data=%h sel=%b cnt=%0d/%0d, want 1 %h %b %0d/%0d",
                     out_valid, out_data, out_sel, cnt_a, cnt_b, front.data, front.sel,
                     exp_cnt_a, exp_cnt_b);
        end
        $display("b2b: beat data=%h sel=%b", out_data, out_sel);
        b_valid = 1'b0;
        if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_sel !== 1'b1 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b data=%h sel=%b pending=%0d, want 0 a5 1 0",
                     out_valid, out_data, out_sel, sb_q.size());
        end
    endtask

    task automatic test_saturation();
        int exp;
        @(negedge clk);
        a2_valid = 1'b1; out2_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            a2_data = 8'(k);
            @(negedge clk);
            exp = (k > 3) ? 3 : k;
            checks++;
            if (cnt2_a !== 2'(exp) || a2_ready !== 1'b1 || out2_data !== 8'(k)) begin
                failures++;
                $display("FAIL sat_beat%0d: cnt_a=%0d a_ready=%b data=%h, want %0d 1 %h",
                         k, cnt2_a, a2_ready, out2_data, exp, 8'(k));
            end
            $display("sat: beat %0d data=%h cnt_a=%0d", k, out2_data, cnt2_a);
        end
        a2_valid = 1'b0;
        checks++;
        if (cnt2_b !== 2'd0) begin
            failures++;
            $display("FAIL sat_cnt_b: cnt_b=%0d, want 0", cnt2_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_alternation();
        test_stall();
        test_back_to_back();
        test_saturation();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
